// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide arbiter.
package muldiv_pkg;

  localparam int DATA_W          = 32;
  localparam int RESULT_W        = 64;
  localparam int TIMEOUT_DEFAULT = 40;
  localparam int CNT_W           = 16;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Turn a requester index into its one-hot strobe position.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone request always wins,
// a tie goes to the requester named by the pointer.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       any
);

  // Pick the winner; grant is only meaningful when any is set.
  always_comb begin
    any   = |req;
    grant = ptr;
    if (req == 2'b01) begin
      grant = 1'b0;
    end else if (req == 2'b10) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one iterative 32-bit multiply/divide unit between two requesters.
// One operation is in flight at a time; the result is held until the owner
// takes it, and a watchdog answers with an error if the unit never finishes.
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_mode,
  input  logic [DATA_W-1:0]   req_a0,
  input  logic [DATA_W-1:0]   req_b0,
  input  logic [DATA_W-1:0]   req_a1,
  input  logic [DATA_W-1:0]   req_b1,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [RESULT_W-1:0] resp_data,
  output logic                resp_err,
  output logic                md_valid,
  output logic                md_mode,
  output logic [DATA_W-1:0]   md_a,
  output logic [DATA_W-1:0]   md_b,
  input  logic                md_ready,
  input  logic [RESULT_W-1:0] md_out
);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          req_ready_q, req_ready_d;
  logic [1:0]          resp_valid_q, resp_valid_d;
  logic [RESULT_W-1:0] resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic                md_valid_q, md_valid_d;
  logic                md_mode_q, md_mode_d;
  logic [DATA_W-1:0]   md_a_q, md_a_d;
  logic [DATA_W-1:0]   md_b_q, md_b_d;

  logic arb_ptr;
  logic arb_grant;
  logic arb_any;

  // Leaving RESP already uses the updated pointer so the other requester can
  // be offered req_ready in the very next cycle.
  assign arb_ptr = (state_q == ST_RESP) ? ~grant_q : ptr_q;

  rr_arb2 u_arb (
    .req   (req_valid),
    .ptr   (arb_ptr),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // Next-state and registered-output decode for the IDLE/ISSUE/WAIT/RESP FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    req_ready_d  = 2'b00;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    md_valid_d   = 1'b0;
    md_mode_d    = md_mode_q;
    md_a_d       = md_a_q;
    md_b_d       = md_b_q;

    case (state_q)
      ST_IDLE: begin
        if ((req_ready_q & req_valid) != 2'b00) begin
          // Handshake completes this cycle; grant_q names the offered bit.
          md_mode_d  = req_mode[grant_q];
          md_a_d     = grant_q ? req_a1 : req_a0;
          md_b_d     = grant_q ? req_b1 : req_b0;
          md_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end else if (arb_any) begin
          // Offer (or re-offer, if the previous offer was withdrawn).
          grant_d     = arb_grant;
          req_ready_d = onehot2(arb_grant);
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (md_ready) begin
          resp_data_d  = md_out;
          resp_err_d   = 1'b0;
          resp_valid_d = onehot2(grant_q);
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = onehot2(grant_q);
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (resp_ready[grant_q]) begin
          resp_valid_d = 2'b00;
          ptr_d        = ~grant_q;
          state_d      = ST_IDLE;
          if (arb_any) begin
            grant_d     = arb_grant;
            req_ready_d = onehot2(arb_grant);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 2'b00;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      md_valid_q   <= 1'b0;
      md_mode_q    <= 1'b0;
      md_a_q       <= '0;
      md_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      md_valid_q   <= md_valid_d;
      md_mode_q    <= md_mode_d;
      md_a_q       <= md_a_d;
      md_b_q       <= md_b_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign md_valid   = md_valid_q;
  assign md_mode    = md_mode_q;
  assign md_a       = md_a_q;
  assign md_b       = md_b_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Testbench for muldiv_arbiter with a behavioural multiply/divide unit that
// pulses md_ready 33 cycles after sampling md_valid.
module tb_muldiv_arbiter;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_mode, resp_valid, resp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, md_a, md_b;
  logic [63:0] resp_data, md_out;
  logic        resp_err, md_valid, md_mode, md_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        stub_en;
  logic        stub_busy;
  int          stub_cnt;
  logic [63:0] stub_res;

  typedef struct {
    logic        id;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  muldiv_arbiter #(.TIMEOUT(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .md_valid   (md_valid),
    .md_mode    (md_mode),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_ready   (md_ready),
    .md_out     (md_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural unit: start sampled in cycle 1, md_ready pulsed in cycle 34.
  always @(posedge clk) begin
    md_ready <= 1'b0;
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= '0;
      md_out    <= '0;
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        stub_busy <= 1'b0;
        md_ready  <= stub_en;
        md_out    <= stub_res;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end else if (md_valid) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 31;
      stub_res  <= md_mode ? {md_a % md_b, md_a / md_b}
                           : ({32'd0, md_a} * {32'd0, md_b});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic mode, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[id] = 1'b1;
    req_mode[id]  = mode;
    if (id) begin
      req_a1 = a;
      req_b1 = b;
    end else begin
      req_a0 = a;
      req_b0 = b;
    end
  endtask

  task automatic wait_accept(input logic id, output int c);
    c = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        c = cyc;
        break;
      end
    end
    chk("accept_seen", 64'(c >= 0), 64'd1);
  endtask

  task automatic wait_resp(input logic id, output int c);
    c = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (resp_valid[id]) begin
        c = cyc;
        break;
      end
    end
    chk("resp_seen", 64'(c >= 0), 64'd1);
  endtask

  // Called at the negedge of the accept cycle: drop valid, check the start pulse.
  task automatic issue_chk(input logic id, input logic mode, input logic [31:0] a,
                           input logic [31:0] b);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    @(negedge clk);
    chk("md_valid_pulse", 64'(md_valid), 64'd1);
    chk("md_mode", 64'(md_mode), 64'(mode));
    chk("md_a", 64'(md_a), 64'(a));
    chk("md_b", 64'(md_b), 64'(b));
    chk("req_ready_one_cycle", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("md_valid_end", 64'(md_valid), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_data"}, resp_data, 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_md_valid"}, 64'(md_valid), 64'd0);
    chk({tag, "_md_mode"}, 64'(md_mode), 64'd0);
    chk({tag, "_md_a"}, 64'(md_a), 64'd0);
    chk({tag, "_md_b"}, 64'(md_b), 64'd0);
  endtask

  // Full single-requester transaction with resp_ready already high.
  task automatic run_op(input logic id, input logic mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_data,
                        input logic exp_err, input int exp_lat);
    int ca, cr;
    @(posedge clk);
    #1 set_req(id, mode, a, b);
    wait_accept(id, ca);
    chk("req_ready_onehot", 64'(req_ready), id ? 64'd2 : 64'd1);
    issue_chk(id, mode, a, b);
    wait_resp(id, cr);
    chk("latency", 64'(cr - ca), 64'(exp_lat));
    chk("resp_valid", 64'(resp_valid), id ? 64'd2 : 64'd1);
    chk("resp_data", resp_data, exp_data);
    chk("resp_err", 64'(resp_err), 64'(exp_err));
    $display("op req%0d mode=%0d a=%h b=%h -> data=%h err=%0d lat=%0d",
             id, mode, a, b, resp_data, resp_err, cr - ca);
    @(negedge clk);
    chk("resp_valid_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int c0, c1, r0, r1;
    logic seen;

    vecs[0] = '{1'b0, MODE_MUL, 32'd6,          32'd7,          64'd42};
    vecs[1] = '{1'b1, MODE_DIV, 32'd100,        32'd7,          64'h00000002_0000000E};
    vecs[2] = '{1'b0, MODE_DIV, 32'hFFFFFFFF,   32'd16,         64'h0000000F_0FFFFFFF};
    vecs[3] = '{1'b1, MODE_MUL, 32'hFFFFFFFF,   32'd2,          64'h00000001_FFFFFFFE};
    vecs[4] = '{1'b0, MODE_MUL, 32'h00010000,   32'h00010000,   64'h00000001_00000000};
    vecs[5] = '{1'b1, MODE_DIV, 32'd5,          32'd9,          64'h00000005_00000000};
    vecs[6] = '{1'b0, MODE_MUL, 32'd0,          32'h12345678,   64'd0};
    vecs[7] = '{1'b1, MODE_DIV, 32'h12345678,   32'd1,          64'h00000000_12345678};

    rst        = 1'b1;
    req_valid  = 2'b00;
    req_mode   = 2'b00;
    req_a0     = '0;
    req_b0     = '0;
    req_a1     = '0;
    req_b1     = '0;
    resp_ready = 2'b11;
    stub_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // Directed vector table, one requester at a time.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].id, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 35);
    end

    // Simultaneous requests: pointer is 0 here, so requester 0 goes first.
    @(posedge clk);
    #1;
    set_req(1'b0, MODE_MUL, 32'd3, 32'd5);
    set_req(1'b1, MODE_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_accept(1'b0, c0);
    chk("rr_first_grant", 64'(req_ready), 64'd1);
    issue_chk(1'b0, MODE_MUL, 32'd3, 32'd5);
    wait_resp(1'b0, r0);
    chk("rr_resp0_data", resp_data, 64'd15);
    chk("rr_resp0_lat", 64'(r0 - c0), 64'd35);
    $display("op req0 pair -> data=%h", resp_data);
    @(negedge clk);
    c1 = cyc;
    chk("rr_second_grant", 64'(req_ready), 64'd2);
    chk("rr_back_to_back", 64'(c1 - c0), 64'd36);
    issue_chk(1'b1, MODE_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_resp(1'b1, r1);
    chk("rr_resp1_data", resp_data, 64'hFFFFFFFE_00000001);
    chk("rr_resp1_lat", 64'(r1 - c1), 64'd35);
    $display("op req1 pair -> data=%h", resp_data);
    @(negedge clk);
    chk("rr_resp1_drop", 64'(resp_valid), 64'd0);

    // Third simultaneous pair: requester 0 wins again.
    @(posedge clk);
    #1;
    set_req(1'b0, MODE_MUL, 32'd3, 32'd5);
    set_req(1'b1, MODE_MUL, 32'd8, 32'd8);
    wait_accept(1'b0, c0);
    chk("rr_third_grant", 64'(req_ready), 64'd1);
    issue_chk(1'b0, MODE_MUL, 32'd3, 32'd5);
    req_valid[1] = 1'b0;
    wait_resp(1'b0, r0);
    chk("rr_third_data", resp_data, 64'd15);
    $display("op req0 third pair -> data=%h", resp_data);
    @(negedge clk);

    // Held response: requester 0 stalls, requester 1 waits; resp_ready[1] ignored.
    resp_ready = 2'b10;
    @(posedge clk);
    #1 set_req(1'b0, MODE_MUL, 32'd9, 32'd9);
    wait_accept(1'b0, c0);
    issue_chk(1'b0, MODE_MUL, 32'd9, 32'd9);
    wait_resp(1'b0, r0);
    set_req(1'b1, MODE_MUL, 32'd4, 32'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_resp_valid", 64'(resp_valid), 64'd1);
      chk("hold_resp_data", resp_data, 64'd81);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 resp_ready = 2'b11;
    @(negedge clk);
    chk("hold_release_cycle", 64'(resp_valid), 64'd1);
    $display("op req0 held -> data=%h", resp_data);
    @(negedge clk);
    chk("hold_after_release", 64'(resp_valid), 64'd0);
    chk("hold_next_grant", 64'(req_ready), 64'd2);
    issue_chk(1'b1, MODE_MUL, 32'd4, 32'd4);
    wait_resp(1'b1, r1);
    chk("hold_req1_data", resp_data, 64'd16);
    $display("op req1 after hold -> data=%h", resp_data);
    @(negedge clk);

    // Watchdog: unit never completes.
    stub_en = 1'b0;
    run_op(1'b0, MODE_MUL, 32'd2, 32'd3, 64'd0, 1'b1, 42);
    stub_en = 1'b1;

    // Reset in the middle of WAIT.
    @(posedge clk);
    #1 set_req(1'b0, MODE_MUL, 32'd5, 32'd5);
    wait_accept(1'b0, c0);
    issue_chk(1'b0, MODE_MUL, 32'd5, 32'd5);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) seen = 1'b1;
    end
    chk("no_resp_after_reset", 64'(seen), 64'd0);
    $display("op req0 aborted by reset, response seen=%0d", seen);
    run_op(1'b0, MODE_MUL, 32'd2, 32'd2, 64'd4, 1'b0, 35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Shares a single 32-bit iterative multiply/divide unit (`mulDiv`) between two requesters, such as the integer pipeline and a coprocessor port.
- Arbitrates requests round-robin and latches operands.
- Issues a one-cycle start pulse to the unit and waits for its one-cycle `ready` pulse.
- Holds the 64-bit result until the owning requester accepts it.
- A watchdog returns an error response if the unit never completes.

## Interface
- `TIMEOUT`, default 40: cycles allowed in WAIT before the watchdog fires. Must be ≥ 35.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: request from requester i (bit i).
- `req_ready` out 2: accept strobe. At most one bit high, for one cycle.
- `req_mode` in 2: per requester; 0 = mulu, 1 = divu.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands for requesters 0 and 1.
- `resp_valid` out 2: result available for requester i. Held until accepted.
- `resp_ready` in 2: requester i consumes the result.
- `resp_data` out 64: result. For mulu: product. For divu: {remainder, quotient}.
- `resp_err` out 1: qualifies `resp_data`; 1 = watchdog timeout, data = 0.
- `md_valid` out 1: start pulse to the unit.
- `md_mode` out 1: mode to the unit.
- `md_a`, `md_b` out 32: operands to the unit.
- `md_ready` in 1: completion pulse from the unit.
- `md_out` in 64: result from the unit.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - If any `req_valid` is set, the round-robin picker selects grant g.
  - `req_ready[g]`=1 for this cycle only.
  - Latch mode, a, b into `md_*` registers and latch g; go to ISSUE.
  - If no request, stay in IDLE.
- **ISSUE**
  - `md_valid`=1 for exactly this cycle; go to WAIT.
  - `md_mode`, `md_a`, `md_b` stay stable from ISSUE until RESP exits.
- **WAIT**
  - Watchdog counter increments each cycle.
  - On `md_ready`: capture `md_out` into the result register, `resp_err`=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without `md_ready`: result=0, `resp_err`=1, go to RESP.
- **RESP**
  - `resp_valid[g]`=1, with `resp_data` and `resp_err` stable.
  - On `resp_ready[g]`: go to IDLE, pointer ← 1−g.
  - `resp_ready` on the non-granted bit is ignored.
- **Round-robin**
  - The pointer names the preferred requester; reset value 0.
  - If only one `req_valid` is set, that requester wins regardless of the pointer.
  - If both are set, the pointer wins.
- Only one operation is in flight. `req_ready` stays 0 outside IDLE, so requests simply wait, with no loss and no reordering.
- A stray `md_ready` outside WAIT is ignored.
- **Reset**
  - All outputs 0, state IDLE, pointer 0, counter 0.
  - Reset mid-operation discards the in-flight result; no response is issued.
  - The unit's own reset is driven from the same source by the top level; this block does not drive it.

## Timing
- Cycle 0: accept (`req_valid[g]` & `req_ready[g]`).
- Cycle 1: `md_valid`.
- The unit samples the start pulse at the end of cycle 1, iterates during cycles 2–33, and pulses `md_ready` in cycle 34.
- `resp_valid` rises in cycle 35; accept-to-response latency is 35 cycles.
- If `resp_ready[g]` is already high in cycle 35, the response lasts one cycle and IDLE occurs in cycle 36.
- The earliest next accept is cycle 36.
- Back-to-back throughput: one operation per 36 cycles.
- Watchdog: timeout response appears TIMEOUT+2 cycles after accept.
- All outputs are registered; `req_ready` is a registered decode of state IDLE and the picker result.

## Structure
- Package `muldiv_pkg` holds:
  - State enum {IDLE, ISSUE, WAIT, RESP}.
  - `MODE_MUL`=0, `MODE_DIV`=1.
  - `DATA_W`=32, `RESULT_W`=64, `TIMEOUT` default.
- Sub-module `rr_arb2`: combinational 2-way round-robin picker. Inputs: request vector and pointer. Outputs: grant index and any-grant.
- The top-level test wrapper instantiates this block plus the existing multiply/divide unit.

## Test plan
- Requester 0 mulu a=6, b=7 → `req_ready[0]` in cycle 0; `resp_valid[0]` in cycle 35; `resp_data`=64'd42; `resp_err`=0.
- Requester 1 divu a=100, b=7 → `resp_data`=64'h00000002_0000000E.
- Both request in the same cycle (requester 0 mulu 3×5, requester 1 mulu 0xFFFFFFFF×0xFFFFFFFF):
  - Requester 0 is served first, with result 15.
  - Requester 1 is served next, with result 64'hFFFFFFFE_00000001.
  - A third simultaneous pair is then served requester 0 first again.
- Hold `resp_ready` low for 10 cycles in RESP → `resp_valid` and data stay stable; a new `req_valid` from the other requester gets no `req_ready` until release.
- Stub unit never asserts `md_ready`, TIMEOUT=40 → `resp_valid` in cycle 42 with `resp_err`=1 and `resp_data`=0.
- Assert `rst` in cycle 20 of WAIT → all outputs 0 next cycle; no response for the aborted request; a fresh 2×2 request afterwards returns 4.
